fu_muldiv_seq: RTL and testbench
================================

Name: fu_muldiv_seq

Overview:
- Multi-cycle initiator for the combinational 8-bit function unit.
- Accepts a multiply or divide request and drives the unit one micro-operation per clock on fu_fs/fu_a/fu_b.
- Samples fu_f and fu_c in the same cycle and accumulates the 16-bit result internally.
- Sits beside the register file/control path and uses the function unit when the control FSM grants it.

Parameters:
WIDTH, 8, operand width; only 8 is supported because it matches the function unit.
ITER, WIDTH, iteration count for both mul and div.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  request strobe; sampled only in IDLE
op  in  1  0 = unsigned multiply, 1 = unsigned divide
opa  in  8  multiplicand-side operand (mul) / dividend (div)
opb  in  8  multiplier-side operand (mul) / divisor (div)
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when result_hi/result_lo become valid
err  out  1  divide-by-zero flag; valid with done, held until next start
result_hi  out  8  mul: product[15:8]; div: remainder
result_lo  out  8  mul: product[7:0]; div: quotient
fu_fs  out  4  function select to the function unit
fu_a  out  8  A operand to the function unit
fu_b  out  8  B operand to the function unit
fu_f  in  8  function unit result, combinational from fu_fs/fu_a/fu_b
fu_c  in  1  function unit carry (A+~B+1: 1 = no borrow)
fu_v, fu_n, fu_z  in  1  function unit flags; ignored in this version

Behaviour:
- Reset (rst high at a clock edge, including mid-operation):
  - state <= IDLE; busy, done, err <= 0; result_hi, result_lo <= 0; internal registers <= 0.
  - Any in-flight operation is abandoned.
- Function-unit outputs: fu_fs/fu_a/fu_b are combinational from state and registers. In IDLE and DONE they are fs=0000, a=0, b=0.
- FS codes used:
  - 0000: F=A
  - 0010: A+B
  - 0101: A+~B+1
  - 1101: shift B right, 0 fill
  - 1110: shift B left, 0 fill
- States: IDLE, STEP_A, STEP_B, DONE.
- IDLE, start=1, opb!=0 or op=0:
  - Load P=0, Q=opa, M=opb, cy=0, rmsb=0, cnt=0.
  - Clear err; go to STEP_A; busy=1 from the next cycle.
- IDLE, start=1, op=1, opb=0:
  - Go to DONE directly; err=1, result_lo=8'hFF, result_hi=opa.
- Multiply, STEP_A (add):
  - fu_fs = Q[0] ? 0010 : 0000; fu_a=P; fu_b=M.
  - P<=fu_f; cy<=Q[0]&fu_c.
- Multiply, STEP_B (shift):
  - fu_fs=1101; fu_b=P.
  - P<={cy,fu_f[6:0]}; Q<={P[0],Q[7:1]}.
- Divide, STEP_A (shift):
  - fu_fs=1110; fu_b=P.
  - P<={fu_f[7:1],Q[7]}; rmsb<=P[7]; Q<={Q[6:0],1'b0}.
- Divide, STEP_B (trial subtract):
  - fu_fs=0101; fu_a=P; fu_b=M.
  - If rmsb|fu_c: P<=fu_f and Q[0]<=1. Otherwise P and Q are unchanged.
- Iteration control:
  - STEP_B: cnt<=cnt+1. If cnt==ITER-1, go to DONE; else go to STEP_A.
- DONE (exactly 1 cycle):
  - done=1, busy=0.
  - result_hi<=P, result_lo<=Q (not updated on the err path); go to IDLE.
- Latency: start accepted at edge k; done high in cycle k+17 (2*ITER+1). The divide-by-zero path has done in cycle k+1.
- start while busy or in DONE is ignored and not queued. op/opa/opb are only sampled at acceptance.
- Results and err hold their values until the next accepted start or reset.
- Arithmetic is unsigned only. Carry-out of P is captured via cy, so the full 16-bit product is exact. Remainder is always < divisor.

Decomposition:
- Shared package: FS code constants (FS_PASS_A, FS_ADD, FS_SUB, FS_SHR_B, FS_SHL_B), the state enum, and the op encoding (OP_MUL, OP_DIV).
- Shared with the function unit and control FSM.
- No sub-module needed: single FSM plus datapath registers.
- Bench instantiates this block with the existing function unit to close the loop.

Test Plan:
- op=0, opa=13, opb=11, start -> done at start+17, result={8'h00,8'h8F}, err=0; busy high exactly 16 cycles.
- op=0, opa=255, opb=255 -> result_hi=8'hFE, result_lo=8'h01 (exercises cy capture on every add).
- op=1, opa=200, opb=7 -> result_lo=28, result_hi=4; op=1, opa=255, opb=1 -> quotient 255, remainder 0; op=1, opa=5, opb=200 -> quotient 0, remainder 5.
- op=1, opa=42, opb=0 -> done one cycle after start, err=1, result_lo=8'hFF, result_hi=42; the next valid op clears err.
- Start mul 13*11, pulse start with op=1 at cycle 5 -> ignored, product still 143. Assert rst at cycle 8 -> next cycle busy=0, results 0, fu_fs=0000; a new start then completes correctly.
- Back-to-back: start asserted in the cycle after done -> accepted, second result correct; fu_fs sequence per iteration matches 0010/0000 then 1101 (mul) or 1110 then 0101 (div).

Source files
------------

// File: rtl/fu_muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// fu_muldiv_seq_pkg
//   Shared definitions for the multi-cycle multiply/divide initiator and the
//   blocks that share the combinational 8-bit function unit with it.
//   Contents:
//     - FS_* : function-select codes understood by the function unit
//     - OP_* : operation encoding on the initiator's op input
//     - state_e : initiator FSM states
// -----------------------------------------------------------------------------
package fu_muldiv_seq_pkg;

  // Function-unit select codes.
  localparam logic [3:0] FS_PASS_A = 4'b0000;  // F = A
  localparam logic [3:0] FS_ADD    = 4'b0010;  // F = A + B, C = carry out
  localparam logic [3:0] FS_SUB    = 4'b0101;  // F = A + ~B + 1, C = 1 means no borrow
  localparam logic [3:0] FS_SHR_B  = 4'b1101;  // F = B >> 1, zero fill
  localparam logic [3:0] FS_SHL_B  = 4'b1110;  // F = B << 1, zero fill

  // Operation encoding.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP_A = 2'd1,
    ST_STEP_B = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage : fu_muldiv_seq_pkg

// File: rtl/fu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// fu_muldiv_seq
//   Multi-cycle unsigned multiply / divide built on the shared combinational
//   function unit. Each iteration is two micro-operations (STEP_A, STEP_B),
//   issued one per clock on fu_fs/fu_a/fu_b; the unit's result (fu_f, fu_c)
//   is folded into the P/Q accumulator in the same cycle.
//
//   Multiply : shift-and-add, P:Q holds the 16-bit product (P = high byte).
//   Divide   : restoring division, Q = quotient, P = remainder.
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   start, op, opa, opb  request; sampled only in IDLE
//   busy                 high while STEP_A/STEP_B are running
//   done                 one-cycle pulse, results and err valid from this cycle
//   err                  divide-by-zero flag, held until next accepted start
//   result_hi/result_lo  mul: product[15:8]/[7:0]; div: remainder/quotient
//   fu_fs, fu_a, fu_b    micro-operation driven to the function unit
//   fu_f, fu_c           function-unit result and carry
//   fu_v, fu_n, fu_z     function-unit flags, not used by this block
// -----------------------------------------------------------------------------
module fu_muldiv_seq
  import fu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic [3:0]       fu_fs,
  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  input  logic [WIDTH-1:0] fu_f,
  input  logic             fu_c,
  input  logic             fu_v,
  input  logic             fu_n,
  input  logic             fu_z
);

  localparam int                CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITER - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   p_q, p_d;        // mul: running high half; div: partial remainder
  logic [WIDTH-1:0]   q_q, q_d;        // mul: multiplier/low half; div: dividend/quotient
  logic [WIDTH-1:0]   m_q, m_d;        // multiplicand / divisor
  logic               cy_q, cy_d;      // carry out of the last multiply add
  logic               rmsb_q, rmsb_d;  // bit shifted out of P in the divide shift
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;

  logic div_by_zero;
  logic last_iter;
  logic unused_flags;

  assign div_by_zero  = (op == OP_DIV) && (opb == '0);
  assign last_iter    = (cnt_q == CNT_LAST);
  assign unused_flags = ^{fu_v, fu_n, fu_z};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge, so a mid-operation rst simply
  // overrides whatever the next-state logic computed for that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      p_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      cy_q     <= 1'b0;
      rmsb_q   <= 1'b0;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      err_q    <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from the values
      // of the previous cycle, independent of statement order.
      state_q  <= state_d;
      p_q      <= p_d;
      q_q      <= q_d;
      m_q      <= m_d;
      cy_q     <= cy_d;
      rmsb_q   <= rmsb_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      err_q    <= err_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaulting every output of a combinational block first means no
    // path can leave it unassigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = div_by_zero ? ST_DONE : ST_STEP_A;
      ST_STEP_A: state_d = ST_STEP_B;
      ST_STEP_B: state_d = last_iter ? ST_DONE : ST_STEP_A;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: status and the micro-operation presented to the function unit
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = (state_q == ST_STEP_A) || (state_q == ST_STEP_B);
    done  = (state_q == ST_DONE);
    fu_fs = FS_PASS_A;
    fu_a  = '0;
    fu_b  = '0;
    unique case (state_q)
      ST_STEP_A: begin
        if (op_q == OP_MUL) begin
          // Passing P through unchanged when the multiplier bit is 0 keeps the
          // datapath update identical for both cases.
          fu_fs = q_q[0] ? FS_ADD : FS_PASS_A;
          fu_a  = p_q;
          fu_b  = m_q;
        end else begin
          fu_fs = FS_SHL_B;
          fu_b  = p_q;
        end
      end
      ST_STEP_B: begin
        if (op_q == OP_MUL) begin
          fu_fs = FS_SHR_B;
          fu_b  = p_q;
        end else begin
          fu_fs = FS_SUB;
          fu_a  = p_q;
          fu_b  = m_q;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    p_d      = p_q;
    q_d      = q_q;
    m_d      = m_q;
    cy_d     = cy_q;
    rmsb_d   = rmsb_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    err_d    = err_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (div_by_zero) begin
            err_d    = 1'b1;
            res_hi_d = opa;
            res_lo_d = '1;
          end else begin
            p_d    = '0;
            q_d    = opa;
            m_d    = opb;
            cy_d   = 1'b0;
            rmsb_d = 1'b0;
            cnt_d  = '0;
            op_d   = op;
            err_d  = 1'b0;
          end
        end
      end

      ST_STEP_A: begin
        if (op_q == OP_MUL) begin
          p_d  = fu_f;
          cy_d = q_q[0] & fu_c;
        end else begin
          // Shift the P:Q pair left by one; P's old MSB is kept in rmsb so the
          // trial subtract can treat P as a 9-bit value.
          p_d    = {fu_f[WIDTH-1:1], q_q[WIDTH-1]};
          rmsb_d = p_q[WIDTH-1];
          q_d    = {q_q[WIDTH-2:0], 1'b0};
        end
      end

      ST_STEP_B: begin
        if (op_q == OP_MUL) begin
          // Shift cy:P:Q right by one; cy supplies the bit lost by the add.
          p_d = {cy_q, fu_f[WIDTH-2:0]};
          q_d = {p_q[0], q_q[WIDTH-1:1]};
        end else if (rmsb_q || fu_c) begin
          p_d = fu_f;
          q_d = {q_q[WIDTH-1:1], 1'b1};
        end
        cnt_d = cnt_q + CNT_W'(1);
        // Capture on the edge into DONE so results are valid with the pulse.
        if (last_iter) begin
          res_hi_d = p_d;
          res_lo_d = q_d;
        end
      end

      default: ;
    endcase
  end

  assign err       = err_q;
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;

endmodule : fu_muldiv_seq

// File: tb/tb_fu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_fu_muldiv_seq
//   Directed bench for fu_muldiv_seq, closed around a behavioural model of the
//   combinational function unit. Expected results are hand-computed.
// -----------------------------------------------------------------------------
module tb_fu_muldiv_seq;
  import fu_muldiv_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       op;
  logic [7:0] opa, opb;
  logic       busy, done, err;
  logic [7:0] result_hi, result_lo;
  logic [3:0] fu_fs;
  logic [7:0] fu_a, fu_b, fu_f;
  logic       fu_c, fu_v, fu_n, fu_z;

  int checks   = 0;
  int failures = 0;

  fu_muldiv_seq #(.WIDTH(8), .ITER(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .fu_fs     (fu_fs),
    .fu_a      (fu_a),
    .fu_b      (fu_b),
    .fu_f      (fu_f),
    .fu_c      (fu_c),
    .fu_v      (fu_v),
    .fu_n      (fu_n),
    .fu_z      (fu_z)
  );

  always #5 clk = ~clk;

  // Function-unit model (only the codes this block issues).
  always_comb begin
    logic [8:0] sum;
    sum  = 9'd0;
    fu_f = 8'h00;
    fu_c = 1'b0;
    case (fu_fs)
      4'b0000: fu_f = fu_a;
      4'b0010: begin sum = {1'b0, fu_a} + {1'b0, fu_b};        fu_f = sum[7:0]; fu_c = sum[8]; end
      4'b0101: begin sum = {1'b0, fu_a} + {1'b0, ~fu_b} + 9'd1; fu_f = sum[7:0]; fu_c = sum[8]; end
      4'b1101: fu_f = {1'b0, fu_b[7:1]};
      4'b1110: fu_f = {fu_b[6:0], 1'b0};
      default: fu_f = 8'h00;
    endcase
    fu_v = 1'b0;
    fu_n = fu_f[7];
    fu_z = (fu_f == 8'h00);
  end

  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Issue one request and follow it to done, sampling on falling edges.
  // inject_at > 0 pulses a div-by-zero start in that busy cycle, which must
  // be ignored.
  task automatic run_op(input string tag, input logic o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_hi, input logic [7:0] exp_lo, input logic exp_err,
                        input int exp_lat, input int inject_at);
    int n           = 0;
    int busy_cycles = 0;
    int fs_errs     = 0;
    logic seen_done = 1'b0;
    logic [3:0] exp_fs;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    // Scramble operands: they must have been captured at acceptance.
    start = 1'b0; op = ~o; opa = 8'h5A; opb = 8'h00;
    while (!seen_done && n < 40) begin
      n++;
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        if (n <= 16) begin
          if (o == OP_MUL) exp_fs = (n % 2 == 1) ? (a[(n-1)/2] ? FS_ADD : FS_PASS_A) : FS_SHR_B;
          else             exp_fs = (n % 2 == 1) ? FS_SHL_B : FS_SUB;
          if (fu_fs !== exp_fs) fs_errs++;
        end
        if (n == inject_at) begin
          start = 1'b1; op = OP_DIV; opb = 8'h00;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 16'(n), 16'(exp_lat));
    check({tag, "_busy_cycles"}, 16'(busy_cycles), 16'(exp_lat - 1));
    check({tag, "_fs_seq_errors"}, 16'(fs_errs), 16'd0);
    check({tag, "_result_hi"}, 16'(result_hi), 16'(exp_hi));
    check({tag, "_result_lo"}, 16'(result_lo), 16'(exp_lo));
    check({tag, "_err"}, 16'(err), 16'(exp_err));
    check({tag, "_done_busy"}, 16'(busy), 16'd0);
    check({tag, "_done_fs"}, 16'(fu_fs), 16'(FS_PASS_A));
  endtask

  // Start 13*11, then reset in cycle 8 of the operation.
  task automatic reset_mid_op();
    @(negedge clk);
    start = 1'b1; op = OP_MUL; opa = 8'd13; opb = 8'd11;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 8; i++) @(negedge clk);
    check("midop_busy_before_rst", 16'(busy), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_result_hi", 16'(result_hi), 16'd0);
    check("rst_result_lo", 16'(result_lo), 16'd0);
    check("rst_fu_fs", 16'(fu_fs), 16'(FS_PASS_A));
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = OP_MUL; opa = 8'h00; opb = 8'h00;
    repeat (2) @(negedge clk);
    check("init_busy", 16'(busy), 16'd0);
    check("init_done", 16'(done), 16'd0);
    check("init_err", 16'(err), 16'd0);
    check("init_result_hi", 16'(result_hi), 16'd0);
    check("init_result_lo", 16'(result_lo), 16'd0);
    check("init_fu_fs", 16'(fu_fs), 16'(FS_PASS_A));
    rst = 1'b0;

    //        tag         op      a       b       hi     lo     err  lat inj
    run_op("mul_13x11",   OP_MUL, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 17, 0);
    run_op("mul_255x255", OP_MUL, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 17, 0);
    run_op("div_200_7",   OP_DIV, 8'd200, 8'd7,   8'd4,  8'd28, 1'b0, 17, 0);
    run_op("div_255_1",   OP_DIV, 8'd255, 8'd1,   8'd0,  8'd255,1'b0, 17, 0);
    run_op("div_5_200",   OP_DIV, 8'd5,   8'd200, 8'd5,  8'd0,  1'b0, 17, 0);
    run_op("div_42_0",    OP_DIV, 8'd42,  8'd0,   8'd42, 8'hFF, 1'b1, 1,  0);
    run_op("mul_ign_start",OP_MUL,8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 17, 5);
    reset_mid_op();
    run_op("mul_200x3",   OP_MUL, 8'd200, 8'd3,   8'h02, 8'h58, 1'b0, 17, 0);
    run_op("div_255_16",  OP_DIV, 8'd255, 8'd16,  8'h0F, 8'h0F, 1'b0, 17, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fu_muldiv_seq
